// File: rtl/core_run_ctrl.sv
// Run sequencer in front of the processor core: holds it in reset while idle,
// releases it for one run per start request, and reports completion/timeout status.
module core_run_ctrl #(
    parameter int             CW      = 16,
    parameter int             RST_CYC = 2,
    parameter logic [CW-1:0]  TIMEOUT = 16'd4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          core_done,
    output logic          core_reset,
    output logic          core_req,
    output logic          busy,
    output logic          finished,
    output logic          timed_out,
    output logic [CW-1:0] cycle_cnt,
    output logic [7:0]    run_cnt
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RST  = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int             RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0] RST_LAST = RCW'(RST_CYC - 1);
    localparam logic [CW-1:0]  TO_LAST  = TIMEOUT - CW'(1);

    logic [1:0]     state;
    logic [RCW-1:0] rst_cnt;

    // Decoded from state only, so no input reaches an output combinationally.
    assign core_reset = (state == S_IDLE) || (state == S_RST);
    assign busy       = (state == S_RST)  || (state == S_RUN);

    // NOTE: all state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_IDLE;
            rst_cnt   <= '0;
            core_req  <= 1'b0;
            finished  <= 1'b0;
            timed_out <= 1'b0;
            cycle_cnt <= '0;
            run_cnt   <= '0;
        end else begin
            core_req <= 1'b0;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_RST;
                        rst_cnt   <= '0;
                        finished  <= 1'b0;
                        timed_out <= 1'b0;
                        cycle_cnt <= '0;
                    end
                end
                S_RST: begin
                    rst_cnt <= rst_cnt + RCW'(1);
                    if (rst_cnt == RST_LAST) begin
                        state    <= S_RUN;
                        core_req <= 1'b1;
                    end
                end
                S_RUN: begin
                    // Completion takes precedence over a coincident timeout.
                    if (core_done) begin
                        state    <= S_DONE;
                        finished <= 1'b1;
                        if (run_cnt != 8'hFF) begin
                            run_cnt <= run_cnt + 8'd1;
                        end
                    end else if (cycle_cnt == TO_LAST) begin
                        state     <= S_DONE;
                        timed_out <= 1'b1;
                        cycle_cnt <= TIMEOUT;
                    end else begin
                        cycle_cnt <= cycle_cnt + CW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl with RST_CYC=2, TIMEOUT=20.
module tb_core_run_ctrl;

    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          core_done;
    logic          core_reset;
    logic          core_req;
    logic          busy;
    logic          finished;
    logic          timed_out;
    logic [CW-1:0] cycle_cnt;
    logic [7:0]    run_cnt;

    int errors = 0;
    int checks = 0;

    core_run_ctrl #(.CW(CW), .RST_CYC(2), .TIMEOUT(16'd20)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .core_done  (core_done),
        .core_reset (core_reset),
        .core_req   (core_req),
        .busy       (busy),
        .finished   (finished),
        .timed_out  (timed_out),
        .cycle_cnt  (cycle_cnt),
        .run_cnt    (run_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic [31:0] cr, input logic [31:0] rq,
                                input logic [31:0] bz, input logic [31:0] fin,
                                input logic [31:0] to, input logic [31:0] cc,
                                input logic [31:0] rc);
        check({tag, ".core_reset"}, 32'(core_reset), cr);
        check({tag, ".core_req"},   32'(core_req),   rq);
        check({tag, ".busy"},       32'(busy),       bz);
        check({tag, ".finished"},   32'(finished),   fin);
        check({tag, ".timed_out"},  32'(timed_out),  to);
        check({tag, ".cycle_cnt"},  32'(cycle_cnt),  cc);
        check({tag, ".run_cnt"},    32'(run_cnt),    rc);
    endtask

    // Start pulse, then two RST edges; returns in the first RUN cycle.
    task automatic start_run();
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        core_done = 1'b0;
        repeat (2) step();
        check_status("reset", 1, 0, 0, 0, 0, 0, 0);
        reset = 1'b0;
        step();

        // Start latency: start sampled at edge 1, RUN entered at edge 3.
        start = 1'b1;
        step();
        start = 1'b0;
        check_status("edge1", 1, 0, 1, 0, 0, 0, 0);
        step();
        check_status("edge2", 1, 0, 1, 0, 0, 0, 0);
        step();
        check_status("edge3_run", 0, 1, 1, 0, 0, 0, 0);
        step();
        check_status("edge4", 0, 0, 1, 0, 0, 1, 0);

        // Normal completion after 10 RUN cycles.
        repeat (9) step();
        check("run10.cycle_cnt", 32'(cycle_cnt), 10);
        core_done = 1'b1;
        step();
        check_status("done10", 0, 0, 0, 1, 0, 10, 1);
        step();
        check_status("done_ignores_core_done", 0, 0, 0, 1, 0, 10, 1);
        core_done = 1'b0;

        // Timeout with core_done held low.
        do_reset();
        check_status("reset2", 1, 0, 0, 0, 0, 0, 0);
        start_run();
        repeat (19) step();
        check_status("pre_timeout", 0, 0, 1, 0, 0, 19, 0);
        step();
        check_status("timeout", 0, 0, 0, 0, 1, 20, 0);
        step();
        check_status("timeout_hold", 0, 0, 0, 0, 1, 20, 0);

        // Restart from DONE clears status; completion on the last legal cycle.
        start = 1'b1;
        step();
        start = 1'b0;
        check_status("restart", 1, 0, 1, 0, 0, 0, 0);
        repeat (2) step();
        repeat (19) step();
        check("edge_cnt19", 32'(cycle_cnt), 19);
        core_done = 1'b1;
        step();
        core_done = 1'b0;
        check_status("done_at_19", 0, 0, 0, 1, 0, 19, 1);

        // start held high through RST and RUN must not restart the run.
        start = 1'b1;
        step();
        check_status("held_rst", 1, 0, 1, 0, 0, 0, 1);
        repeat (2) step();
        check_status("held_run0", 0, 1, 1, 0, 0, 0, 1);
        repeat (2) step();
        check_status("held_run2", 0, 0, 1, 0, 0, 2, 1);
        core_done = 1'b1;
        step();
        start     = 1'b0;
        core_done = 1'b0;
        check_status("held_done", 0, 0, 0, 1, 0, 2, 2);

        // Reset in the middle of a run.
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (2) step();
        repeat (7) step();
        check("midrun.cycle_cnt", 32'(cycle_cnt), 7);
        do_reset();
        check_status("midrun_reset", 1, 0, 0, 0, 0, 0, 0);
        step();
        check_status("idle_stays", 1, 0, 0, 0, 0, 0, 0);

        // Back-to-back immediate completions: each run takes 4 edges, 1200 edges is > 255 runs.
        start     = 1'b1;
        core_done = 1'b1;
        repeat (1200) step();
        start     = 1'b0;
        core_done = 1'b0;
        check("run_cnt_saturated", 32'(run_cnt), 255);
        check("sat_exclusive", 32'(finished & timed_out), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
